// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared opcode, field and state definitions for the instruction reader
package instr_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_LDI = 4'd8
  } opcode_t;

  localparam int OPC_HI = 11;
  localparam int OPC_LO = 8;
  localparam int A_HI   = 7;
  localparam int A_LO   = 4;
  localparam int B_HI   = 3;
  localparam int B_LO   = 0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LATCH,
    EXEC
  } rd_state_t;

endpackage

// File: rtl/instr_alu.sv
// rtl/instr_alu.sv - combinational 8-bit ALU executing one decoded instruction
module instr_alu
  import instr_pkg::*;
#(
  parameter int RES_W = 8
) (
  input  logic [3:0]       opcode,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [RES_W-1:0] result,
  output logic [RES_W-1:0] next_result,
  output logic             illegal
);

  opcode_t          op;
  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;
  logic [RES_W-1:0] ab;

  assign op    = opcode_t'(opcode);
  assign a_ext = RES_W'(a);
  assign b_ext = RES_W'(b);
  assign ab    = RES_W'({a, b});

  // Illegal opcodes leave the accumulator untouched; the top suppresses the valid strobe.
  always_comb begin
    next_result = result;
    illegal     = 1'b0;
    case (op)
      OP_NOP:  next_result = result;
      OP_ADD:  next_result = a_ext + b_ext;
      OP_SUB:  next_result = a_ext - b_ext;
      OP_MUL:  next_result = a_ext * b_ext;
      OP_AND:  next_result = ab & result;
      OP_OR:   next_result = ab | result;
      OP_XOR:  next_result = ab ^ result;
      OP_SHL:  next_result = result << b[2:0];
      OP_LDI:  next_result = ab;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_exec_reader.sv
// rtl/instr_exec_reader.sv - FIFO consumer that fetches, executes and reports 12-bit instructions
module instr_exec_reader
  import instr_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int RES_W      = 8,
  parameter int IDLE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              rd_en,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  output logic              err,
  output logic [7:0]        instr_count,
  output logic              clock_disable
);

  localparam int CNT_W = $clog2(IDLE_LIMIT + 1);

  rd_state_t         state;
  rd_state_t         state_next;
  logic [DATA_W-1:0] instr_q;
  logic [CNT_W-1:0]  idle_cnt;
  logic [RES_W-1:0]  alu_result;
  logic              alu_illegal;
  logic              fetch_ok;
  logic              starved;

  assign fetch_ok = en && !fifo_empty;
  assign starved  = (state == IDLE) && en && fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    case (state)
      IDLE:    if (fetch_ok) state_next = FETCH;
      FETCH: begin
        rd_en      = 1'b1;
        state_next = LATCH;
      end
      LATCH:   state_next = EXEC;
      EXEC:    state_next = fetch_ok ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The FIFO read port is registered, so the popped word is only valid one cycle after FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  instr_q <= '0;
    else if (state == LATCH)  instr_q <= fifo_data;
  end

  instr_alu #(.RES_W(RES_W)) u_alu (
    .opcode      (instr_q[OPC_HI:OPC_LO]),
    .a           (instr_q[A_HI:A_LO]),
    .b           (instr_q[B_HI:B_LO]),
    .result      (result),
    .next_result (alu_result),
    .illegal     (alu_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      instr_count  <= 8'd0;
    end else begin
      result_valid <= 1'b0;
      err          <= 1'b0;
      if (state == EXEC) begin
        instr_count <= instr_count + 8'd1;
        if (alu_illegal) begin
          err <= 1'b1;
        end else begin
          result       <= alu_result;
          result_valid <= 1'b1;
        end
      end
    end
  end

  // Registered one cycle ahead so the request is high in the IDLE_LIMIT-th starved cycle
  // and drops in the cycle right after fifo_empty falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt      <= '0;
      clock_disable <= 1'b0;
    end else if (starved) begin
      if (32'(idle_cnt) < IDLE_LIMIT) idle_cnt <= idle_cnt + CNT_W'(1);
      clock_disable <= (32'(idle_cnt) + 32'd2 >= 32'(IDLE_LIMIT));
    end else begin
      idle_cnt      <= '0;
      clock_disable <= 1'b0;
    end
  end

endmodule
